// File: rtl/mem_responder.sv
// mem_responder: far-end memory/bus responder for a small processor.
// Decodes the processor address into RAM, ROM and a 4-byte I/O window, and
// returns read data combinationally (zero wait states). A host load port fills
// RAM/ROM while the processor is held in reset. The processor is released a
// fixed number of cycles after the host signals completion.
// I/O window: +0 timer low byte, +1 latched timer high byte, +2 output byte
// port, +3 run status.
// Optional build macro: MEM_RESPONDER_VECTOR_OVERRIDE_EN makes reads of
// 0xFFFC/0xFFFD return RESET_VECTOR instead of ROM contents.
module mem_responder #(
    parameter int          RAM_DEPTH      = 2048,
    parameter logic [15:0] ROM_BASE       = 16'hF000,
    parameter logic [15:0] IO_BASE        = 16'h8000,
    parameter int          RELEASE_CYCLES = 4,
    parameter logic [15:0] RESET_VECTOR   = 16'hF000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic [7:0]  rd_data,
    output logic        cpu_resetn,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_data,
    input  logic        ld_done,
    output logic [7:0]  out_data,
    output logic        out_valid
);

    localparam int ROM_DEPTH = 65536 - int'(ROM_BASE);
    localparam int RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int ROM_AW    = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam int CNT_W     = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [16:0]      RAM_END  = 17'(RAM_DEPTH);

    // The regions must be disjoint: RAM below the I/O window, I/O window
    // below ROM, and the window aligned so its low two bits select a register.
    if (RAM_DEPTH < 1 || RAM_DEPTH > int'(IO_BASE) ||
        int'(IO_BASE) + 4 > int'(ROM_BASE) || IO_BASE[1:0] != 2'b00 ||
        RELEASE_CYCLES < 1) begin : g_bad_map
        $error("mem_responder: illegal or overlapping address map parameters");
    end

    typedef enum logic [2:0] {
        S_LOAD    = 3'b001,
        S_RELEASE = 3'b010,
        S_RUN     = 3'b100
    } state_t;

    typedef enum logic [1:0] {
        RG_NONE,
        RG_RAM,
        RG_ROM,
        RG_IO
    } region_t;

    // I/O wins over ROM, ROM wins over RAM; anything else is unmapped.
    function automatic region_t f_region(input logic [15:0] a);
        if (a[15:2] == IO_BASE[15:2])
            return RG_IO;
        else if (a >= ROM_BASE)
            return RG_ROM;
        else if ({1'b0, a} < RAM_END)
            return RG_RAM;
        else
            return RG_NONE;
    endfunction

    logic [7:0]        r_ram [RAM_DEPTH];
    logic [7:0]        r_rom [ROM_DEPTH];

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_cpu_resetn;
    logic [CNT_W-1:0]  r_rel_cnt;
    logic [15:0]       r_timer;
    logic [7:0]        r_timer_hi;
    logic [7:0]        r_out_data;
    logic              r_out_valid;

    region_t           w_rd_region;
    region_t           w_ld_region;
    logic [ROM_AW-1:0] w_rom_idx;
    logic [ROM_AW-1:0] w_ld_rom_idx;
    logic              w_run;
    logic              w_ld_ready;
    logic              w_ram_we;
    logic [RAM_AW-1:0] w_ram_waddr;
    logic [7:0]        w_ram_wdata;
    logic              w_rom_we;
    logic [7:0]        w_rd_data;

    assign w_rd_region  = f_region(address);
    assign w_ld_region  = f_region(ld_addr);
    assign w_rom_idx    = ROM_AW'(address - ROM_BASE);
    assign w_ld_rom_idx = ROM_AW'(ld_addr - ROM_BASE);
    assign w_run        = (r_state == S_RUN);

    assign rd_data    = w_rd_data;
    assign cpu_resetn = r_cpu_resetn;
    assign ld_ready   = w_ld_ready;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;

    // Next-state logic and load-port handshake for the LOAD/RELEASE/RUN sequencer
    always_comb begin
        w_state_nxt = r_state;
        w_ld_ready  = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_ld_ready = 1'b1;
                if (ld_done)
                    w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (r_rel_cnt == CNT_LAST)
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    // State register; processor reset is released together with entry to RUN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_LOAD;
            r_cpu_resetn <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cpu_resetn <= (w_state_nxt == S_RUN);
        end
    end

    // Release delay counter, timer with coherent high-byte latch, output port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rel_cnt   <= '0;
            r_timer     <= 16'h0000;
            r_timer_hi  <= 8'h00;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
        end else begin
            r_rel_cnt   <= (r_state == S_RELEASE) ? r_rel_cnt + 1'b1 : '0;
            r_timer     <= w_run ? r_timer + 16'h0001 : 16'h0000;
            r_out_valid <= 1'b0;
            if (w_run && !wr_en && address == IO_BASE)
                r_timer_hi <= r_timer[15:8];
            if (w_run && wr_en && address == IO_BASE + 16'h0002) begin
                r_out_data  <= wr_data;
                r_out_valid <= 1'b1;
            end
        end
    end

    // Write-port steering: host beats while loading, processor stores to RAM in RUN
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_waddr = ld_addr[RAM_AW-1:0];
        w_ram_wdata = ld_data;
        w_rom_we    = 1'b0;
        if (w_ld_ready && ld_valid) begin
            w_ram_we = (w_ld_region == RG_RAM);
            w_rom_we = (w_ld_region == RG_ROM);
        end else if (w_run && wr_en && w_rd_region == RG_RAM) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = address[RAM_AW-1:0];
            w_ram_wdata = wr_data;
        end
    end

    // Memory arrays are never reset so a reset does not lose loaded contents
    always_ff @(posedge clk) begin
        if (w_ram_we)
            r_ram[w_ram_waddr] <= w_ram_wdata;
        if (w_rom_we)
            r_rom[w_ld_rom_idx] <= ld_data;
    end

    // Zero-wait-state read mux
    always_comb begin
        w_rd_data = 8'hFF;
        case (w_rd_region)
            RG_IO: begin
                case (address[1:0])
                    2'd0:    w_rd_data = r_timer[7:0];
                    2'd1:    w_rd_data = r_timer_hi;
                    2'd2:    w_rd_data = r_out_data;
                    default: w_rd_data = {7'b0, w_run};
                endcase
            end
            RG_ROM: begin
`ifdef MEM_RESPONDER_VECTOR_OVERRIDE_EN
                if (address == 16'hFFFC)
                    w_rd_data = RESET_VECTOR[7:0];
                else if (address == 16'hFFFD)
                    w_rd_data = RESET_VECTOR[15:8];
                else
                    w_rd_data = r_rom[w_rom_idx];
`else
                w_rd_data = r_rom[w_rom_idx];
`endif
            end
            RG_RAM: begin
                w_rd_data = r_ram[address[RAM_AW-1:0]];
            end
            default: begin
                w_rd_data = 8'hFF;
            end
        endcase
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory/bus responder: the far end of the processor's address/rd_data interface.
- Decodes each processor address into RAM, ROM and a small I/O window, and returns rd_data in the same cycle (zero wait states).
- A host load port fills RAM/ROM while the responder holds the processor in reset. After loading, it releases the processor.
- The I/O window provides a cycle timer and an output byte port.

Parameters:
- RAM_DEPTH, 2048: RAM bytes, mapped at 0x0000 to RAM_DEPTH-1.
- ROM_BASE, 16'hF000: first ROM address. ROM extends to 0xFFFF (depth 65536-ROM_BASE).
- IO_BASE, 16'h8000: base of the 4-byte I/O window.
- RELEASE_CYCLES, 4: cycles cpu_resetn stays low after ld_done.
- RESET_VECTOR, 16'hF000: vector value used only with the optional feature.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- address, in, 16: processor address.
- wr_en, in, 1: processor write strobe (reserved for stores).
- wr_data, in, 8: processor write data.
- rd_data, out, 8: read data for address.
- cpu_resetn, out, 1: active-low reset driven to the processor.
- ld_valid, in, 1: host load beat valid.
- ld_ready, out, 1: responder accepts load beats.
- ld_addr, in, 16: load address.
- ld_data, in, 8: load byte.
- ld_done, in, 1: host signals load complete (level or pulse).
- out_data, out, 8: last byte written to the output port.
- out_valid, out, 1: one-cycle pulse on each output-port write.

Behaviour:
- One clock domain, clk. reset is asynchronous, active-high.
- Reset values:
  - state=LOAD, cpu_resetn=0, ld_ready=1.
  - timer=0, timer_hi_latch=0, out_data=0, out_valid=0.
  - RAM/ROM contents are NOT cleared.
- Read path: rd_data is combinational from address (asynchronous array read). The processor registers address and samples rd_data at the next edge, so no latency is permitted.
  - RAM range: RAM[address].
  - ROM range: ROM[address-ROM_BASE].
  - IO_BASE+0: timer[7:0].
  - IO_BASE+1: timer_hi_latch.
  - IO_BASE+2: out_data.
  - IO_BASE+3: {7'b0, state==RUN}.
  - Unmapped: 8'hFF.
- Range priority: I/O, then ROM, then RAM. Overlapping parameter choices are illegal and flagged by an elaboration-time check.
- State machine, one-hot, three states:
  - LOAD: ld_ready=1. A beat transfers when ld_valid&&ld_ready, writing ld_data to RAM or ROM. Beats to I/O or unmapped addresses are acknowledged and dropped. When ld_done=1 (sampled at the edge), go to RELEASE and clear the release counter. If a beat and ld_done coincide, the beat is written, then the state transitions.
  - RELEASE: ld_ready=0. The counter increments each cycle. When count==RELEASE_CYCLES-1, go to RUN.
  - RUN: ld_ready=0, cpu_resetn=1 (registered, asserted in the first RUN cycle). RUN is terminal until reset.
- cpu_resetn is 0 in LOAD and RELEASE.
- Processor writes (RUN only, wr_en=1):
  - RAM: updated.
  - ROM: ignored.
  - IO_BASE+2: out_data<=wr_data and out_valid=1 for exactly one cycle.
  - Other I/O or unmapped addresses: ignored.
  - wr_en outside RUN: ignored.
- Timer:
  - 16-bit counter, increments every cycle in RUN, wraps 0xFFFF->0x0000, holds at 0 in LOAD/RELEASE.
  - On any RUN edge where address==IO_BASE and wr_en=0, timer_hi_latch<=timer[15:8], taken from the same cycle as the returned low byte. This gives a coherent 16-bit read of LSB then MSB.
- Reset mid-operation: any state returns to LOAD, cpu_resetn drops asynchronously, loaded memory is retained. The host may skip reloading by asserting ld_done.

Optional Feature:
- Macro: MEM_RESPONDER_VECTOR_OVERRIDE_EN.
- Defined: reads of 0xFFFC return RESET_VECTOR[7:0] and reads of 0xFFFD return RESET_VECTOR[15:8], regardless of ROM contents. Load beats to those addresses still write ROM, but the stored values are shadowed.
- Undefined: 0xFFFC/0xFFFD read from ROM like any other ROM address.

Test Plan:
- Load and release:
  - Stimulus: reset, then load 0xFFFC=0x00, 0xFFFD=0xF0, 0xF000=0xEA, then ld_done.
  - Required response: cpu_resetn stays 0 for exactly 4 cycles after ld_done, then goes 1. ld_ready=0 from RELEASE onward. Reading 0xF000 gives rd_data=0xEA in the same cycle.
- Region decode:
  - Stimulus: addresses 0x0010 (loaded 0x5A), 0x4000, 0xF000.
  - Required response: rd_data 0x5A, 0xFF, ROM byte respectively. Load beat to 0x8002 is dropped and out_valid stays 0.
- Writes in RUN:
  - Stimulus: wr_en to 0x0020 with 0x33, then 0xF001 with 0x77, then 0x8002 with 0x41.
  - Required response: 0x0020 reads 0x33. 0xF001 is unchanged. out_data=0x41 with a single out_valid pulse.
- Timer coherence:
  - Stimulus: force timer to 0x12FF by waiting, read 0x8000 then 0x8001 on consecutive cycles.
  - Required response: reads return 0xFF then 0x12, not 0x13.
  - Also check: wrap from 0xFFFF goes to 0x0000.
- Reset mid-RELEASE:
  - Stimulus: assert reset two cycles after ld_done.
  - Required response: cpu_resetn=0 immediately, state LOAD, ld_ready=1. Previously loaded 0xF000 still reads 0xEA.
- Vector override:
  - Stimulus: with the macro defined and RESET_VECTOR=16'hF000, ROM loaded with 0xFFFC=0x34, 0xFFFD=0x12.
  - Required response: reads return 0x00/0xF0.
  - Without the macro: reads return 0x34/0x12.
